mem_stage_bus: RTL and testbench

- MEM-stage data bus of the five-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Decodes the ALU-computed address into one of three targets: word-addressed data RAM, a memory-mapped peripheral page (timer, LEDs, 7-seg digits, systick), or unmapped space.
- Returns load data combinationally in the same cycle. Performs stores on the clock edge.

---
 rtl/mem_stage_bus_pkg.sv | 44 ++++
 rtl/mem_stage_bus_mmio_timer.sv | 45 ++++
 rtl/mem_stage_bus.sv | 92 +++++++++
 tb/tb_mem_stage_bus.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_bus_pkg.sv
// Shared definitions for the MEM-stage data bus: peripheral page map,
// TCON bit positions and the address-decode helper.
package mem_stage_bus_pkg;

   localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
   localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
   localparam logic [31:0] ADDR_DIGIT   = 32'h4000_0010;
   localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

   localparam int unsigned TCON_EN     = 0;
   localparam int unsigned TCON_IRQ_EN = 1;
   localparam int unsigned TCON_IRQ    = 2;

   typedef enum logic [2:0] {
      TGT_RAM,
      TGT_TH,
      TGT_TL,
      TGT_TCON,
      TGT_LED,
      TGT_DIGIT,
      TGT_SYSTICK,
      TGT_NONE
   } target_t;

   // Byte-lane bits are ignored: every access is a full word.
   function automatic target_t decode_target(input logic [31:0] addr,
                                             input logic [31:0] ram_bytes);
      logic [31:0] word;
      word = {addr[31:2], 2'b00};
      if (addr < ram_bytes) return TGT_RAM;
      case (word)
         ADDR_TH:      return TGT_TH;
         ADDR_TL:      return TGT_TL;
         ADDR_TCON:    return TGT_TCON;
         ADDR_LED:     return TGT_LED;
         ADDR_DIGIT:   return TGT_DIGIT;
         ADDR_SYSTICK: return TGT_SYSTICK;
         default:      return TGT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_bus_mmio_timer.sv
// Memory-mapped reload timer: TH (reload value), TL (counter), TCON
// (enable, irq enable, irq flag). CPU writes override the timer update.
module mmio_timer
   import mem_stage_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_th,
   input  logic        wr_tl,
   input  logic        wr_tcon,
   input  logic [31:0] write_data,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon
);

   logic wrap;

   assign wrap = tcon[TCON_EN] && (tl == '1);

   // Timer registers: count/reload TL, latch irq on reload when enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (wr_th)
            th <= write_data;

         if (wr_tl)
            tl <= write_data;
         else if (wrap)
            tl <= th;
         else if (tcon[TCON_EN])
            tl <= tl + 32'd1;

         if (wr_tcon)
            tcon <= write_data[2:0];
         else if (wrap && tcon[TCON_IRQ_EN])
            tcon[TCON_IRQ] <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_bus.sv
// MEM-stage data bus: decodes the ALU address into data RAM, the
// peripheral page or unmapped space; combinational loads, clocked stores.
module mem_stage_bus
   import mem_stage_bus_pkg::*;
#(
   parameter int unsigned RAM_WORDS     = 256,
   parameter int unsigned RAM_ADDR_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data,
   output logic        o_irq,
   output logic [7:0]  o_leds,
   output logic [11:0] o_digits,
   output logic [31:0] o_systick
);

   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   logic [31:0]              ram [RAM_WORDS];
   logic [RAM_ADDR_BITS-1:0] word_idx;
   target_t                  target;
   logic [31:0]              th;
   logic [31:0]              tl;
   logic [2:0]               tcon;
   logic [7:0]               leds;
   logic [11:0]              digits;
   logic [31:0]              systick;

   assign target   = decode_target(i_addr, RAM_BYTES);
   assign word_idx = i_addr[RAM_ADDR_BITS+1:2];

   mmio_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .wr_th      (i_mem_write && (target == TGT_TH)),
      .wr_tl      (i_mem_write && (target == TGT_TL)),
      .wr_tcon    (i_mem_write && (target == TGT_TCON)),
      .write_data (i_write_data),
      .th         (th),
      .tl         (tl),
      .tcon       (tcon)
   );

   // Data RAM store; contents survive reset but a store under reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && i_mem_write && (target == TGT_RAM))
         ram[word_idx] <= i_write_data;
   end

   // LED and 7-seg registers plus the free-running systick counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leds    <= '0;
         digits  <= '0;
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;
         if (i_mem_write && (target == TGT_LED))
            leds <= i_write_data[7:0];
         if (i_mem_write && (target == TGT_DIGIT))
            digits <= i_write_data[11:0];
      end
   end

   // Zero-latency load mux; narrow registers are zero-extended.
   always_comb begin
      o_read_data = '0;
      if (i_mem_read) begin
         case (target)
            TGT_RAM:     o_read_data = ram[word_idx];
            TGT_TH:      o_read_data = th;
            TGT_TL:      o_read_data = tl;
            TGT_TCON:    o_read_data = {29'd0, tcon};
            TGT_LED:     o_read_data = {24'd0, leds};
            TGT_DIGIT:   o_read_data = {20'd0, digits};
            TGT_SYSTICK: o_read_data = systick;
            default:     o_read_data = '0;
         endcase
      end
   end

   assign o_irq     = tcon[TCON_IRQ];
   assign o_leds    = leds;
   assign o_digits  = digits;
   assign o_systick = systick;

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus: RAM, decode, timer, peripherals, reset.
module tb_mem_stage_bus;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [31:0] i_addr;
   logic [31:0] i_write_data;
   logic [31:0] o_read_data;
   logic        o_irq;
   logic [7:0]  o_leds;
   logic [11:0] o_digits;
   logic [31:0] o_systick;

   int tests  = 0;
   int failed = 0;
   int ticks  = 0;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_DIG  = 32'h4000_0010;
   localparam logic [31:0] A_TICK = 32'h4000_0014;

   mem_stage_bus #(.RAM_WORDS(256), .RAM_ADDR_BITS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_mem_read   (i_mem_read),
      .i_mem_write  (i_mem_write),
      .i_addr       (i_addr),
      .i_write_data (i_write_data),
      .o_read_data  (o_read_data),
      .o_irq        (o_irq),
      .o_leds       (o_leds),
      .o_digits     (o_digits),
      .o_systick    (o_systick)
   );

   always #5 clk = ~clk;

   // Reference cycle count for systick.
   always @(posedge clk or posedge reset) begin
      if (reset) ticks <= 0;
      else       ticks <= ticks + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one bus cycle mid-period; any store commits at the next posedge.
   task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      i_mem_read   = rd;
      i_mem_write  = wr;
      i_addr       = a;
      i_write_data = d;
      #1;
   endtask

   initial begin
      reset = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0; i_addr = '0; i_write_data = '0;
      #2;
      check("rst_irq",   {31'd0, o_irq},      32'd0);
      check("rst_leds",  {24'd0, o_leds},     32'd0);
      check("rst_digits",{20'd0, o_digits},   32'd0);
      check("rst_tick",  o_systick,           32'd0);
      @(negedge clk); reset = 1'b0;

      bus(1, 0, A_TCON, 0);        check("rst_tcon", o_read_data, 32'd0);
      bus(1, 0, A_TL, 0);          check("rst_tl",   o_read_data, 32'd0);

      // RAM store/load, misaligned, read-during-write
      bus(0, 1, 32'h10, 32'hDEADBEEF);
      bus(1, 0, 32'h10, 0);        check("ram_ld",    o_read_data, 32'hDEADBEEF);
      bus(1, 0, 32'h12, 0);        check("ram_misal", o_read_data, 32'hDEADBEEF);
      bus(1, 1, 32'h10, 32'h12345678); check("ram_rdw_old", o_read_data, 32'hDEADBEEF);
      bus(1, 0, 32'h10, 0);        check("ram_rdw_new", o_read_data, 32'h12345678);

      // Unmapped, gated and RAM-boundary behaviour
      bus(0, 1, 32'h0, 32'hA5A50000);
      bus(0, 1, 32'h3FC, 32'h11);
      bus(1, 0, 32'h30000000, 0);  check("unmap_rd", o_read_data, 32'd0);
      bus(0, 1, 32'h30000000, 32'hFFFFFFFF);
      bus(0, 1, 32'h400, 32'hFFFFFFFF);
      bus(1, 0, 32'h0, 0);         check("unmap_wr", o_read_data, 32'hA5A50000);
      bus(1, 0, 32'h3FC, 0);       check("ram_top",  o_read_data, 32'h11);
      bus(1, 0, 32'h400, 0);       check("ram_end",  o_read_data, 32'd0);
      bus(0, 0, 32'h10, 0);        check("gated_rd", o_read_data, 32'd0);

      // Timer reload and irq
      bus(0, 1, A_TH, 32'hFFFFFFFE);
      bus(0, 1, A_TL, 32'hFFFFFFFE);
      bus(0, 1, A_TCON, 32'd3);
      bus(1, 0, A_TL, 0);          check("tl_0", o_read_data, 32'hFFFFFFFE);
      bus(1, 0, A_TL, 0);          check("tl_1", o_read_data, 32'hFFFFFFFF);
                                   check("irq_pre", {31'd0, o_irq}, 32'd0);
      bus(1, 0, A_TL, 0);          check("tl_reload", o_read_data, 32'hFFFFFFFE);
                                   check("irq_set", {31'd0, o_irq}, 32'd1);
      bus(1, 1, A_TCON, 32'd3);    check("tcon_irq", o_read_data, 32'd7);
                                   check("irq_hold", {31'd0, o_irq}, 32'd1);
      bus(0, 1, A_TCON, 32'd1);    check("irq_clr", {31'd0, o_irq}, 32'd0);

      // CPU write to TL wins over a reload in the same cycle
      bus(0, 1, A_TL, 32'd5);
      bus(1, 0, A_TL, 0);          check("coll_tl5", o_read_data, 32'd5);
      bus(1, 0, A_TL, 0);          check("coll_tl6", o_read_data, 32'd6);
      bus(1, 0, A_TCON, 0);        check("tcon_rb", o_read_data, 32'd1);

      // Peripherals
      bus(0, 1, A_LED, 32'h1A5);
      bus(0, 1, A_DIG, 32'hF3F);
      bus(1, 0, A_LED, 0);         check("led_rb",  o_read_data, 32'hA5);
                                   check("led_out", {24'd0, o_leds}, 32'hA5);
      bus(1, 0, A_DIG, 0);         check("dig_rb",  o_read_data, 32'hF3F);
                                   check("dig_out", {20'd0, o_digits}, 32'hF3F);
      bus(1, 0, A_TICK, 0);        check("tick_rd", o_read_data, 32'(ticks));
      bus(0, 1, A_TICK, 32'd0);
      bus(1, 0, A_TICK, 0);        check("tick_ro", o_read_data, 32'(ticks));
                                   check("tick_out", o_systick, 32'(ticks));

      // Async reset mid-operation, with a store in flight
      bus(0, 1, A_TCON, 32'd3);
      bus(0, 1, A_TL, 32'hFFFFFFFF);
      bus(0, 1, A_LED, 32'hFF);
      bus(0, 0, 32'h0, 0);         check("pre_irq",  {31'd0, o_irq}, 32'd1);
                                   check("pre_leds", {24'd0, o_leds}, 32'hFF);
      i_mem_write = 1'b1; i_addr = 32'h10; i_write_data = 32'h77;
      #1 reset = 1'b1;
      #1;
      check("ar_irq",    {31'd0, o_irq},    32'd0);
      check("ar_leds",   {24'd0, o_leds},   32'd0);
      check("ar_digits", {20'd0, o_digits}, 32'd0);
      check("ar_tick",   o_systick,         32'd0);
      @(negedge clk);
      i_mem_write = 1'b0;
      reset = 1'b0;
      #1;                          check("rel_tick0", o_systick, 32'd0);
      bus(1, 0, 32'h10, 0);        check("rel_tick1", o_systick, 32'd1);
                                   check("ram_kept",  o_read_data, 32'h12345678);
      bus(0, 0, 0, 0);             check("rel_tick2", o_systick, 32'd2);
      bus(0, 0, 0, 0);             check("rel_tick3", o_systick, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
